uart_rx_nq: RTL and testbench
=============================

Name: uart_rx_nq

Overview:
- Serial receiver matching the team's programmable-baud UART transmitter (8N1, LSB first, idle high).
- Baud divisor is {DBH,DBL}, the same 13-bit value the transmitter uses, so one register pair drives both directions.
- Bit period = divisor+1 clocks, matching the transmitter's reload-then-count-to-zero timing.
- Sits between the RX pin and the SPART/bus interface; that logic reads rx_data and clears rdy.

Parameters:
- SYNC_STAGES, 2, number of metastability flops on RX; minimum 2.

Ports:
- clk      input   1   system clock
- rst      input   1   synchronous reset, active-high
- RX       input   1   asynchronous serial input, idle high
- clr_rdy  input   1   single-cycle pulse from consumer: byte taken, clear rdy
- DBL      input   8   baud divisor low byte
- DBH      input   5   baud divisor high bits
- rx_data  output  8   last received byte
- rdy      output  1   byte available (set/reset flag)
- frm_err  output  1   stop bit of last byte sampled low

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Every flop resets only on a clk edge with rst=1.
- Reset values:
  - synchronizer flops 1 (line idle)
  - state IDLE, bit_cnt 0, baud_cnt 0
  - shift_reg 9'h1FF, rx_data 8'h00, rdy 0, frm_err 0
- Synchronizer: RX passes through SYNC_STAGES flops (rx_s). Falling-edge detect = previous rx_s high and current rx_s low.
- divisor = {DBH,DBL}, 13 bits unsigned. It is sampled when a start edge is detected; changes mid-byte take effect at the next reload.
- States:
  - IDLE: on falling edge, load baud_cnt = divisor>>1 (half-bit point), bit_cnt=0, go to RECV.
  - RECV: baud_cnt decrements each clock. When baud_cnt==0 (the sample strobe):
    - shift rx_s into shift_reg MSB (shift right)
    - bit_cnt++
    - reload baud_cnt = divisor
- Sample 0 is the start bit. If that sample is 1, it was a false start: return to IDLE, no flag changes.
- After the 10th sample (bit_cnt reaches 10) go to IDLE on the next clock, which also loads the outputs:
  - rx_data = shift_reg[7:0] (the data bits)
  - rdy = 1
  - frm_err = ~stop bit
- Latency: rdy rises exactly 1 clock after the stop-bit sample strobe.
- rdy clear and overrun:
  - clr_rdy clears rdy next clock.
  - If clr_rdy and byte-complete land in the same cycle, set wins: rdy=1 and new data is loaded.
  - Overrun (new byte while rdy=1): rx_data is overwritten, rdy stays 1. No overrun flag.
- frm_err updates only at byte completion; clr_rdy also clears it.
- Divisor 0 or 1: bit period is 1 or 2 clocks and the half-load is 0. Behaviour must remain deterministic; no protection is provided.
- Reset mid-byte: immediate return to reset values, partial byte discarded.
- IDLE ignores a line held low (break) until a new high-to-low edge is seen.
- baud_cnt decrements only in RECV, for low power.

Decomposition:
- Shared package uart_pkg:
  - state_t enum {IDLE, RECV}, shared with the transmitter when it is refactored
  - DIV_W=13
  - BITS_PER_FRAME=10
  - reset divisor constant 13'h01B2
- One natural sub-module: uart_sync (parameterised N-flop synchronizer with reset-to-1 and falling-edge output). It is reusable on other async inputs.
- The datapath and FSM stay in uart_rx_nq.

Test Plan:
- Divisor {DBH,DBL}=13'h00F (16 clk/bit); drive 0x5A framed 8N1 → rdy rises 1 clk after the 10th strobe, rx_data=8'h5A, frm_err=0. Sample strobes fall at 8,24,40,… clocks after the edge reaches rx_s.
- Loopback the existing transmitter TX→RX, divisor 13'h01B2, bytes 0x00, 0xFF, 0xA5, 0x3C back-to-back, pulsing clr_rdy after each → every byte received intact, rdy toggles once per byte.
- Glitch: RX low for 4 clocks at divisor 15 → start sample reads 1, state returns to IDLE, rdy stays 0, rx_data unchanged.
- Framing: send 0x81 with stop bit 0 → rx_data=8'h81, rdy=1, frm_err=1. Next clean byte 0x7E → frm_err=0.
- Simultaneity: assert clr_rdy in the exact cycle a second byte 0x33 completes → rdy=1, rx_data=8'h33. Then rst=1 mid-frame of a third byte → next clock all outputs at reset values, and a later fresh byte is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, divisor width, frame length and the
// power-on baud divisor used by both the transmitter and the receiver.
package uart_pkg;
  typedef enum logic {IDLE, RECV} state_t;

  localparam int DIV_W          = 13;
  localparam int BITS_PER_FRAME = 10;
  localparam logic [DIV_W-1:0] DIV_RST = 13'h01B2;
endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous, idle-high input, with a
// registered falling-edge strobe on the synchronized output.
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);
  logic [N-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], din};
    prev_d = sync_q[N-1];
  end

  // Reset to 1 so a line that idles high does not look like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[N-1];
  assign fall = prev_q & ~sync_q[N-1];
endmodule

// File: rtl/uart_rx_nq.sv
// 8N1 receiver, LSB first, bit period {DBH,DBL}+1 clocks. Samples mid-bit,
// publishes each byte with a set/reset rdy flag and a framing-error flag.
module uart_rx_nq
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  input  logic [7:0] DBL,
  input  logic [4:0] DBH,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);
  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_FRAME);

  logic             rx_s, rx_fall;
  logic [DIV_W-1:0] divisor;
  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rdy_q, rdy_d;
  logic             frm_err_q, frm_err_d;

  uart_sync #(.N(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (RX),
    .dout (rx_s),
    .fall (rx_fall)
  );

  assign divisor = {DBH, DBL};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q;
    frm_err_d  = frm_err_q;
    if (clr_rdy) begin
      rdy_d     = 1'b0;
      frm_err_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          baud_cnt_d = divisor >> 1;
          bit_cnt_d  = 4'd0;
          state_d    = RECV;
        end
      end
      RECV: begin
        // Completion is checked first so a byte finishing overrides clr_rdy.
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = IDLE;
          rx_data_d = shift_q[7:0];
          rdy_d     = 1'b1;
          frm_err_d = ~shift_q[8];
        end else if (baud_cnt_q == '0) begin
          shift_d    = {rx_s, shift_q[8:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          baud_cnt_d = divisor;
          if (bit_cnt_q == 4'd0 && rx_s) state_d = IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= '0;
      shift_q    <= 9'h1FF;
      rx_data_q  <= 8'h00;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;
endmodule

// File: tb/tb_uart_rx_nq.sv
// Directed bench for uart_rx_nq: a bit-banged 8N1 transmitter drives RX and
// a scoreboard of expected {frm_err,data} is checked after each frame.
module tb_uart_rx_nq;
  import uart_pkg::*;

  // Posedges from driving the start bit until rdy is seen high at divisor 15:
  // sync delay, half-bit load, 9 further bit periods, shift, completion.
  localparam int LAT = (2 - 1) + (15 / 2 + 1) + 1 + 9 * 16 + 1 + 1;

  logic        clk = 1'b0;
  logic        rst, RX, clr_rdy;
  logic [12:0] div;
  logic [7:0]  rx_data;
  logic        rdy, frm_err;

  int errors = 0, checks = 0;
  int cyc = 0, start_cyc = 0, rise_cyc = -1, rise_cnt = 0;
  logic rdy_prev = 1'b0;
  logic [8:0] sb_q[$];

  uart_rx_nq #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .DBL     (div[7:0]),
    .DBH     (div[12:8]),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rdy === 1'b1 && rdy_prev !== 1'b1) begin
      rise_cyc = cyc;
      rise_cnt = rise_cnt + 1;
    end
    rdy_prev = rdy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a negedge; optionally pulses clr_rdy for the
  // single cycle beginning at negedge index clr_at of the frame.
  task automatic send(input logic [7:0] data, input logic stop, input int clr_at);
    int per;
    logic [9:0] frame;
    per   = int'(div) + 1;
    frame = {stop, data, 1'b0};
    sb_q.push_back({~stop, data});
    start_cyc = cyc;
    rise_cyc  = -1;
    for (int b = 0; b < 10; b++) begin
      RX = frame[b];
      for (int k = 0; k < per; k++) begin
        clr_rdy = (b * per + k == clr_at);
        @(negedge clk);
      end
    end
    RX      = 1'b1;
    clr_rdy = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    logic [8:0] e;
    chk({tag, "_sb_size"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_data"}, rx_data, e[7:0]);
      chk({tag, "_ferr"}, frm_err, e[8]);
      chk({tag, "_rdy"},  rdy, 1'b1);
    end
  endtask

  task automatic pulse_clr(input string tag);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    chk({tag, "_clr_rdy"},  rdy, 1'b0);
    chk({tag, "_clr_ferr"}, frm_err, 1'b0);
  endtask

  initial begin
    logic [7:0] lb [4];
    int rc;
    lb = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    rst = 1'b1; RX = 1'b1; clr_rdy = 1'b0; div = 13'h00F;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy",  rdy, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", frm_err, 1'b0);
    repeat (4) @(negedge clk);

    // Basic byte and exact rdy latency at 16 clk/bit.
    send(8'h5A, 1'b1, -1);
    chk("lat_5a", rise_cyc - start_cyc, LAT);
    sb_check("b5a");
    pulse_clr("b5a");

    // Short low glitch: false start, nothing changes.
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rdy",  rdy, 1'b0);
    chk("glitch_data", rx_data, 8'h5A);

    // Framing error then a clean byte.
    send(8'h81, 1'b0, -1);
    sb_check("b81");
    pulse_clr("b81");
    send(8'h7E, 1'b1, -1);
    sb_check("b7e");

    // rdy still set from 0x7E: clr_rdy lands in the completion cycle of 0x33.
    send(8'h33, 1'b1, LAT - 1);
    sb_check("b33");

    // Reset in the middle of a frame.
    RX = 1'b0;
    repeat (40) @(negedge clk);
    RX = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("mrst_rdy",  rdy, 1'b0);
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_ferr", frm_err, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(8'hC3, 1'b1, -1);
    sb_check("bc3");
    pulse_clr("bc3");

    // Transmitter-rate loopback at the power-on divisor.
    div = DIV_RST;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rc = rise_cnt;
      send(lb[i], 1'b1, -1);
      sb_check($sformatf("lb%0d", i));
      chk($sformatf("lb%0d_rises", i), rise_cnt - rc, 1);
      pulse_clr($sformatf("lb%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
